// File: rtl/data_unloader_8_if.sv
// Bridge-read and byte-memory signals of the 8-bit unloader, bundled for port connection.
// The slave modport is the unloader; the master modport is the bridge plus memory side.
interface data_unloader_8_if #(
    parameter int unsigned ADDRESS_SIZE = 15
);
    logic                    bridge_rd;
    logic                    bridge_endian_little;
    logic [31:0]             bridge_addr;
    logic [31:0]             bridge_rd_data;
    logic                    busy;
    logic                    read_en;
    logic [ADDRESS_SIZE-1:0] read_addr;
    logic [7:0]              read_data;

    modport master (
        output bridge_rd, bridge_endian_little, bridge_addr, read_data,
        input  bridge_rd_data, busy, read_en, read_addr
    );

    modport slave (
        input  bridge_rd, bridge_endian_little, bridge_addr, read_data,
        output bridge_rd_data, busy, read_en, read_addr
    );
endinterface

// File: rtl/data_unloader_8.sv
// Services APF bridge reads by fetching four bytes from an 8-bit synchronous
// memory port and presenting them as one 32-bit word in the selected endianness.
module data_unloader_8 #(
    parameter logic [3:0]  ADDRESS_MASK_UPPER_4 = 4'h0,
    parameter int unsigned ADDRESS_SIZE         = 15,
    parameter int unsigned READ_MEM_LATENCY     = 1
) (
    input  logic             clk_74a,
    input  logic             reset,
    data_unloader_8_if.slave bus
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned CNT_W    = 2;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDRESS_SIZE-1:0] base_q, base_d;
    logic                    little_q, little_d;
    logic [WORD_W-1:0]       stage_q, stage_d;
    logic [WORD_W-1:0]       rd_data_q, rd_data_d;
    logic                    busy_q, busy_d;
    logic                    read_en_q, read_en_d;
    logic [ADDRESS_SIZE-1:0] read_addr_q, read_addr_d;

    logic       accept_c;
    logic [1:0] lane_c;
    logic       unused_addr_c;

    // Address bits outside the memory window and the sub-word offset are don't-care.
    assign unused_addr_c = ^{bus.bridge_addr[27:ADDRESS_SIZE], bus.bridge_addr[1:0]};

    // Acceptance tracks the FSM itself so a new read is taken the cycle after DONE.
    assign accept_c = bus.bridge_rd && (state_q == S_IDLE) &&
                      (bus.bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);

    // Byte k lands in lane k (little) or lane 3-k (big).
    assign lane_c = little_q ? k_q : ~k_q;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        little_d    = little_q;
        stage_d     = stage_q;
        rd_data_d   = rd_data_q;
        read_addr_d = read_addr_q;
        read_en_d   = 1'b0;
        busy_d      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    base_d   = {bus.bridge_addr[ADDRESS_SIZE-1:2], 2'b00};
                    little_d = bus.bridge_endian_little;
                    k_d      = 2'd0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                read_en_d   = 1'b1;
                read_addr_d = base_q + ADDRESS_SIZE'(k_q);
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    stage_d[{lane_c, 3'b000} +: 8] = bus.read_data;
                    if (k_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                rd_data_d = stage_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            cnt_q       <= '0;
            base_q      <= '0;
            little_q    <= 1'b0;
            stage_q     <= '0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            read_en_q   <= 1'b0;
            read_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            little_q    <= little_d;
            stage_q     <= stage_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            read_en_q   <= read_en_d;
            read_addr_q <= read_addr_d;
        end
    end

    assign bus.bridge_rd_data = rd_data_q;
    assign bus.busy           = busy_q;
    assign bus.read_en        = read_en_q;
    assign bus.read_addr      = read_addr_q;

endmodule
